axi_master_arbiter: RTL and testbench
=====================================

Name: axi_master_arbiter

Overview:
- Shares one axi_master user-side request interface between NUM_REQ requesters, using round-robin arbitration.
- Latches the granted requester's command and issues a one-cycle wr_tx/rd_tx pulse to axi_master, holding the command fields stable.
- Waits for wr_done/rd_done, routes read data and completion back to the owner, and applies a watchdog timeout.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
TIMEOUT_CYCLES, 1024, cycles waited for done before abort; 0 disables the timeout

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high
req_valid  in  NUM_REQ  per-requester request; level, held with fields until req_grant
req_write  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*32  start address, slice i = [32i+31:32i]
req_len  in  NUM_REQ*8  beats-1
req_size  in  NUM_REQ*3  beat size
req_burst  in  NUM_REQ*2  00 FIXED, 01 INCR, 10 WRAP
req_wdata  in  NUM_REQ*32  write start data
req_grant  out  NUM_REQ  one-cycle accept pulse; requester may drop/change fields after
req_done  out  NUM_REQ  one-cycle completion pulse to owner
req_err  out  1  valid with req_done; 1 = timeout abort
req_rd_valid  out  NUM_REQ  rd_data_valid routed to owner only
req_rd_data  out  32  rd_data, broadcast
busy  out  1  state != IDLE
wr_tx, rd_tx  out  1 each  to axi_master, one-cycle pulses
wr_addr, wr_len, wr_size, wr_burst, wr_data  out  32/8/3/2/32  to axi_master, held from issue until done
rd_addr, rd_len, rd_size, rd_burst  out  32/8/3/2  to axi_master, held from issue until done
wr_done, rd_done, rd_data_valid  in  1 each  from axi_master
rd_data  in  32  from axi_master

Behaviour:
- Reset (sync): state IDLE, rr_ptr=0, timeout counter 0. All outputs 0 (req_grant, req_done, req_err, req_rd_valid, req_rd_data, busy, wr_tx, rd_tx, all wr_*/rd_* fields).
- Mid-transaction reset abandons the owner with no req_done. axi_master shares this reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE: if any req_valid is high at edge E, pick the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ. Registered at E:
  - owner = chosen index.
  - req_grant[owner]=1 and exactly one of wr_tx/rd_tx = 1, both for the cycle after E.
  - Chosen fields copied to wr_* (write) or rd_* (read). The other channel's fields are unchanged.
  - Timeout counter cleared; state WAIT.
  - Latency from req_valid sampled to tx pulse: 1 cycle.
- WAIT:
  - Only the done matching the latched op counts; the other done is ignored.
  - On matching done at edge E: state DONE, req_done[owner]=1 and req_err=0 for one cycle, rr_ptr=(owner+1) mod NUM_REQ.
  - Otherwise the counter increments. If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 without done: DONE with req_err=1 and the same rr_ptr update.
  - Done and timeout expiry on the same edge: done wins, req_err=0.
- DONE: lasts one cycle, then IDLE. Earliest next grant is 2 cycles after done is sampled. Field outputs hold their values until the next issue overwrites them.
- Read data: req_rd_valid[owner] = rd_data_valid, combinational, gated to state WAIT with a read op owner. req_rd_data = rd_data. rd_data_valid is ignored in IDLE/DONE or during a write.
- Fairness: a continuously requesting requester is granted at most once before each other active requester is granted once.
- req_valid dropped before grant is legal; that requester is simply not selected.
- Field widths pass through unmodified; the arbiter performs no length or address arithmetic.

Test Plan:
- Single write: req0 write addr 0x1000, len 3, INCR, wdata 0x100. Required: req_grant[0] and wr_tx in the same cycle, 1 cycle after req_valid. wr_addr=0x1000 held until wr_done. req_done[0] 1 cycle after wr_done, req_err=0.
- Contention: req0 and req1 both valid from reset with continuous requests. Required grant order 0,1,0,1. No grant while busy. Each tx pulse is exactly 1 cycle.
- Read routing: req1 read 0x2000, len 7, with the slave returning 0x200..0x207. Required: 8 pulses on req_rd_valid[1] with req_rd_data matching, req_rd_valid[0] never high, then req_done[1].
- Spurious done: req0 write in WAIT, bench pulses rd_done. Required: no state change. A subsequent wr_done completes the transaction normally.
- Timeout: TIMEOUT_CYCLES=16, no done returned. Required: req_done[0]=1 with req_err=1 exactly 16 cycles after the issue cycle, then IDLE, next request granted. Done on the 16th cycle gives req_err=0.
- Reset in WAIT: assert reset for 1 cycle mid-read. Required: all outputs 0, busy=0, no req_done, rr_ptr=0, so req0 wins the next simultaneous request.

Source files
------------

// File: rtl/axi_master_arbiter.sv
// Round-robin arbiter sharing one axi_master user port between NUM_REQ requesters.
// Issues one-cycle wr_tx/rd_tx, routes read data and completion to the owner, with a watchdog.
module axi_master_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [NUM_REQ*32-1:0]  req_addr,
    input  logic [NUM_REQ*8-1:0]   req_len,
    input  logic [NUM_REQ*3-1:0]   req_size,
    input  logic [NUM_REQ*2-1:0]   req_burst,
    input  logic [NUM_REQ*32-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     req_grant,
    output logic [NUM_REQ-1:0]     req_done,
    output logic                   req_err,
    output logic [NUM_REQ-1:0]     req_rd_valid,
    output logic [31:0]            req_rd_data,
    output logic                   busy,
    output logic                   wr_tx,
    output logic                   rd_tx,
    output logic [31:0]            wr_addr,
    output logic [7:0]             wr_len,
    output logic [2:0]             wr_size,
    output logic [1:0]             wr_burst,
    output logic [31:0]            wr_data,
    output logic [31:0]            rd_addr,
    output logic [7:0]             rd_len,
    output logic [2:0]             rd_size,
    output logic [1:0]             rd_burst,
    input  logic                   wr_done,
    input  logic                   rd_done,
    input  logic                   rd_data_valid,
    input  logic [31:0]            rd_data
);
    localparam int          IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NUM_REQ_U    = NUM_REQ;
    localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYCLES != 0) ? 32'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               op_write_q, op_write_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0] req_grant_q, req_grant_d;
    logic [NUM_REQ-1:0] req_done_q, req_done_d;
    logic               req_err_q, req_err_d;
    logic               wr_tx_q, wr_tx_d, rd_tx_q, rd_tx_d;
    logic [31:0]        wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
    logic [7:0]         wr_len_q, wr_len_d;
    logic [2:0]         wr_size_q, wr_size_d;
    logic [1:0]         wr_burst_q, wr_burst_d;
    logic [31:0]        rd_addr_q, rd_addr_d;
    logic [7:0]         rd_len_q, rd_len_d;
    logic [2:0]         rd_size_q, rd_size_d;
    logic [1:0]         rd_burst_q, rd_burst_d;

    logic [31:0]        addr_a  [NUM_REQ];
    logic [7:0]         len_a   [NUM_REQ];
    logic [2:0]         size_a  [NUM_REQ];
    logic [1:0]         burst_a [NUM_REQ];
    logic [31:0]        wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = req_addr[32*g +: 32];
        assign len_a[g]   = req_len[8*g +: 8];
        assign size_a[g]  = req_size[3*g +: 3];
        assign burst_a[g] = req_burst[2*g +: 2];
        assign wdata_a[g] = req_wdata[32*g +: 32];
    end

    logic             any_valid;
    logic [IDX_W-1:0] pick;
    int unsigned      scan;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
        scan      = 0;
        for (int unsigned k = 0; k < NUM_REQ_U; k++) begin
            scan = (32'(rr_ptr_q) + k) % NUM_REQ_U;
            if (!any_valid && req_valid[IDX_W'(scan)]) begin
                any_valid = 1'b1;
                pick      = IDX_W'(scan);
            end
        end
    end

    logic             done_hit;
    logic             timeout_hit;
    logic [IDX_W-1:0] owner_next;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        op_write_d  = op_write_q;
        cnt_d       = cnt_q;
        req_grant_d = '0;
        req_done_d  = '0;
        req_err_d   = 1'b0;
        wr_tx_d     = 1'b0;
        rd_tx_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_len_d    = wr_len_q;
        wr_size_d   = wr_size_q;
        wr_burst_d  = wr_burst_q;
        wr_data_d   = wr_data_q;
        rd_addr_d   = rd_addr_q;
        rd_len_d    = rd_len_q;
        rd_size_d   = rd_size_q;
        rd_burst_d  = rd_burst_q;
        done_hit    = op_write_q ? wr_done : rd_done;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_LAST);
        owner_next  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    owner_d           = pick;
                    op_write_d        = req_write[pick];
                    req_grant_d[pick] = 1'b1;
                    cnt_d             = '0;
                    state_d           = ST_WAIT;
                    if (req_write[pick]) begin
                        wr_tx_d    = 1'b1;
                        wr_addr_d  = addr_a[pick];
                        wr_len_d   = len_a[pick];
                        wr_size_d  = size_a[pick];
                        wr_burst_d = burst_a[pick];
                        wr_data_d  = wdata_a[pick];
                    end else begin
                        rd_tx_d    = 1'b1;
                        rd_addr_d  = addr_a[pick];
                        rd_len_d   = len_a[pick];
                        rd_size_d  = size_a[pick];
                        rd_burst_d = burst_a[pick];
                    end
                end
            end
            ST_WAIT: begin
                // A done on the expiry edge still completes cleanly.
                if (done_hit || timeout_hit) begin
                    state_d             = ST_DONE;
                    req_done_d[owner_q] = 1'b1;
                    req_err_d           = !done_hit;
                    rr_ptr_d            = owner_next;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            op_write_q  <= 1'b0;
            cnt_q       <= '0;
            req_grant_q <= '0;
            req_done_q  <= '0;
            req_err_q   <= 1'b0;
            wr_tx_q     <= 1'b0;
            rd_tx_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_len_q    <= '0;
            wr_size_q   <= '0;
            wr_burst_q  <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= '0;
            rd_len_q    <= '0;
            rd_size_q   <= '0;
            rd_burst_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            op_write_q  <= op_write_d;
            cnt_q       <= cnt_d;
            req_grant_q <= req_grant_d;
            req_done_q  <= req_done_d;
            req_err_q   <= req_err_d;
            wr_tx_q     <= wr_tx_d;
            rd_tx_q     <= rd_tx_d;
            wr_addr_q   <= wr_addr_d;
            wr_len_q    <= wr_len_d;
            wr_size_q   <= wr_size_d;
            wr_burst_q  <= wr_burst_d;
            wr_data_q   <= wr_data_d;
            rd_addr_q   <= rd_addr_d;
            rd_len_q    <= rd_len_d;
            rd_size_q   <= rd_size_d;
            rd_burst_q  <= rd_burst_d;
        end
    end

    always_comb begin
        req_rd_valid = '0;
        if (state_q == ST_WAIT && !op_write_q) begin
            req_rd_valid[owner_q] = rd_data_valid;
        end
    end

    assign req_rd_data = rd_data;
    assign busy        = (state_q != ST_IDLE);
    assign req_grant   = req_grant_q;
    assign req_done    = req_done_q;
    assign req_err     = req_err_q;
    assign wr_tx       = wr_tx_q;
    assign rd_tx       = rd_tx_q;
    assign wr_addr     = wr_addr_q;
    assign wr_len      = wr_len_q;
    assign wr_size     = wr_size_q;
    assign wr_burst    = wr_burst_q;
    assign wr_data     = wr_data_q;
    assign rd_addr     = rd_addr_q;
    assign rd_len      = rd_len_q;
    assign rd_size     = rd_size_q;
    assign rd_burst    = rd_burst_q;
endmodule

// File: tb/tb_axi_master_arbiter.sv
// Scoreboard bench for axi_master_arbiter: stimulus pushes expected grant/done/read-data
// events with their cycle; a negedge monitor pops and compares whenever the DUT emits one.
`timescale 1ns/1ps
module tb_axi_master_arbiter;
    localparam int NUM_REQ = 2;
    localparam int TMO     = 16;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_write = '0;
    logic [NUM_REQ*32-1:0] req_addr = '0;
    logic [NUM_REQ*8-1:0]  req_len = '0;
    logic [NUM_REQ*3-1:0]  req_size = '0;
    logic [NUM_REQ*2-1:0]  req_burst = '0;
    logic [NUM_REQ*32-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]    req_grant, req_done, req_rd_valid;
    logic                  req_err, busy, wr_tx, rd_tx;
    logic [31:0]           req_rd_data;
    logic [31:0]           wr_addr, wr_data, rd_addr;
    logic [7:0]            wr_len, rd_len;
    logic [2:0]            wr_size, rd_size;
    logic [1:0]            wr_burst, rd_burst;
    logic                  wr_done = 1'b0, rd_done = 1'b0, rd_data_valid = 1'b0;
    logic [31:0]           rd_data = '0;

    axi_master_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
        .req_size(req_size), .req_burst(req_burst), .req_wdata(req_wdata),
        .req_grant(req_grant), .req_done(req_done), .req_err(req_err),
        .req_rd_valid(req_rd_valid), .req_rd_data(req_rd_data), .busy(busy),
        .wr_tx(wr_tx), .rd_tx(rd_tx),
        .wr_addr(wr_addr), .wr_len(wr_len), .wr_size(wr_size), .wr_burst(wr_burst), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_len(rd_len), .rd_size(rd_size), .rd_burst(rd_burst),
        .wr_done(wr_done), .rd_done(rd_done), .rd_data_valid(rd_data_valid), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NUM_REQ-1:0] mask;
        logic               wr;
        logic [31:0]        addr;
        logic [7:0]         len;
        logic [2:0]         size;
        logic [1:0]         burst;
        logic [31:0]        data;
        int                 cyc;
    } grant_exp_t;
    typedef struct {
        logic [NUM_REQ-1:0] mask;
        logic               err;
        int                 cyc;
    } done_exp_t;
    typedef struct {
        logic [NUM_REQ-1:0] mask;
        logic [31:0]        data;
        int                 cyc;
    } rd_exp_t;

    grant_exp_t grant_q[$];
    done_exp_t  done_q[$];
    rd_exp_t    rd_q[$];
    grant_exp_t ge;
    done_exp_t  de;
    rd_exp_t    re;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (req_grant != '0 || wr_tx || rd_tx) begin
                if (grant_q.size() == 0) begin
                    check("grant_unexpected", {wr_tx, rd_tx, req_grant}, '0);
                end else begin
                    ge = grant_q.pop_front();
                    check("grant_mask", req_grant, ge.mask);
                    check("grant_cycle", cyc, ge.cyc);
                    check("wr_tx", wr_tx, ge.wr);
                    check("rd_tx", rd_tx, !ge.wr);
                    if (ge.wr) begin
                        check("wr_addr", wr_addr, ge.addr);
                        check("wr_len", wr_len, ge.len);
                        check("wr_size", wr_size, ge.size);
                        check("wr_burst", wr_burst, ge.burst);
                        check("wr_data", wr_data, ge.data);
                    end else begin
                        check("rd_addr", rd_addr, ge.addr);
                        check("rd_len", rd_len, ge.len);
                        check("rd_size", rd_size, ge.size);
                        check("rd_burst", rd_burst, ge.burst);
                    end
                end
            end
            if (req_done != '0 || req_err) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", {req_err, req_done}, '0);
                end else begin
                    de = done_q.pop_front();
                    check("done_mask", req_done, de.mask);
                    check("done_err", req_err, de.err);
                    check("done_cycle", cyc, de.cyc);
                end
            end
            if (req_rd_valid != '0) begin
                if (rd_q.size() == 0) begin
                    check("rd_valid_unexpected", req_rd_valid, '0);
                end else begin
                    re = rd_q.pop_front();
                    check("rd_valid_mask", req_rd_valid, re.mask);
                    check("rd_data", req_rd_data, re.data);
                    check("rd_cycle", cyc, re.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [1:0] b, input logic [31:0] d);
        req_write[i]          = w;
        req_addr[32*i +: 32]  = a;
        req_len[8*i +: 8]     = l;
        req_size[3*i +: 3]    = s;
        req_burst[2*i +: 2]   = b;
        req_wdata[32*i +: 32] = d;
        req_valid[i]          = 1'b1;
    endtask

    task automatic push_grant(input int i, input logic w, input logic [31:0] a, input logic [7:0] l,
                              input logic [2:0] s, input logic [1:0] b, input logic [31:0] d,
                              input int c);
        grant_exp_t e;
        e.mask    = '0;
        e.mask[i] = 1'b1;
        e.wr      = w;
        e.addr    = a;
        e.len     = l;
        e.size    = s;
        e.burst   = b;
        e.data    = d;
        e.cyc     = c;
        grant_q.push_back(e);
    endtask

    task automatic push_done(input int i, input logic err, input int c);
        done_exp_t e;
        e.mask    = '0;
        e.mask[i] = 1'b1;
        e.err     = err;
        e.cyc     = c;
        done_q.push_back(e);
    endtask

    task automatic push_rd(input int i, input logic [31:0] d, input int c);
        rd_exp_t e;
        e.mask    = '0;
        e.mask[i] = 1'b1;
        e.data    = d;
        e.cyc     = c;
        rd_q.push_back(e);
    endtask

    // Requester presents a request while the arbiter is idle: grant expected on the next cycle.
    task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b, input logic [31:0] d);
        set_req(i, w, a, l, s, b, d);
        push_grant(i, w, a, l, s, b, d, cyc + 1);
    endtask

    task automatic wait_grant(input int i);
        logic [NUM_REQ-1:0] m;
        bit seen;
        m    = '0;
        m[i] = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 64 && !seen; n++) begin
            if (req_grant[i]) seen = 1'b1;
            else tick();
        end
        if (!seen) check("grant_wait_expired", req_grant, m);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 64 && busy; n++) tick();
        if (busy) check("idle_wait_expired", busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string w);
        check({w, "_req_grant"}, req_grant, '0);
        check({w, "_req_done"}, req_done, '0);
        check({w, "_req_err"}, req_err, '0);
        check({w, "_req_rd_valid"}, req_rd_valid, '0);
        check({w, "_req_rd_data"}, req_rd_data, '0);
        check({w, "_busy"}, busy, '0);
        check({w, "_wr_tx"}, wr_tx, '0);
        check({w, "_rd_tx"}, rd_tx, '0);
        check({w, "_wr_addr"}, wr_addr, '0);
        check({w, "_wr_len"}, wr_len, '0);
        check({w, "_wr_size"}, wr_size, '0);
        check({w, "_wr_burst"}, wr_burst, '0);
        check({w, "_wr_data"}, wr_data, '0);
        check({w, "_rd_addr"}, rd_addr, '0);
        check({w, "_rd_len"}, rd_len, '0);
        check({w, "_rd_size"}, rd_size, '0);
        check({w, "_rd_burst"}, rd_burst, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL sim_watchdog: got=still running exp=finished");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int own;
        int g;

        // Reset state
        tick();
        tick();
        check_reset_outputs("init");
        reset = 1'b0;

        // Single write
        issue(0, 1'b1, 32'h1000, 8'd3, 3'd2, 2'b01, 32'h100);
        wait_grant(0);
        req_valid[0] = 1'b0;
        repeat (3) begin
            tick();
            check("t1_wr_addr_hold", wr_addr, 32'h1000);
            check("t1_busy", busy, 1'b1);
        end
        wr_done = 1'b1;
        push_done(0, 1'b0, cyc + 1);
        tick();
        wr_done = 1'b0;
        check("t1_wr_addr_at_done", wr_addr, 32'h1000);
        wait_idle();

        // Contention from reset: continuous requests, grants alternate 0,1,0,1
        reset = 1'b1;
        tick();
        set_req(0, 1'b1, 32'hA000, 8'd1, 3'd2, 2'b01, 32'hAAAA);
        set_req(1, 1'b0, 32'hB000, 8'd0, 3'd1, 2'b10, 32'h0);
        tick();
        reset = 1'b0;
        push_grant(0, 1'b1, 32'hA000, 8'd1, 3'd2, 2'b01, 32'hAAAA, cyc + 1);
        for (int n = 0; n < 4; n++) begin
            own = n % 2;
            wait_grant(own);
            tick();
            tick();
            if (own == 0) wr_done = 1'b1;
            else rd_done = 1'b1;
            push_done(own, 1'b0, cyc + 1);
            if (n < 3) begin
                if (own == 0) push_grant(1, 1'b0, 32'hB000, 8'd0, 3'd1, 2'b10, 32'h0, cyc + 3);
                else push_grant(0, 1'b1, 32'hA000, 8'd1, 3'd2, 2'b01, 32'hAAAA, cyc + 3);
            end else begin
                req_valid = '0;
            end
            tick();
            wr_done = 1'b0;
            rd_done = 1'b0;
        end
        wait_idle();

        // Read routing; rd_data_valid while idle must not reach anyone
        rd_data_valid = 1'b1;
        rd_data       = 32'hDEAD0000;
        tick();
        rd_data_valid = 1'b0;
        rd_data       = '0;
        issue(1, 1'b0, 32'h2000, 8'd7, 3'd2, 2'b01, 32'h0);
        wait_grant(1);
        req_valid[1] = 1'b0;
        for (int b = 0; b < 8; b++) begin
            rd_data_valid = 1'b1;
            rd_data       = 32'h200 + b;
            push_rd(1, 32'h200 + b, cyc);
            tick();
            rd_data_valid = 1'b0;
            if (b == 3) tick();
        end
        check("t3_rd_addr_hold", rd_addr, 32'h2000);
        rd_done = 1'b1;
        push_done(1, 1'b0, cyc + 1);
        tick();
        rd_done = 1'b0;
        rd_data = '0;
        wait_idle();

        // Spurious rd_done and rd_data_valid during a write
        issue(0, 1'b1, 32'h4000, 8'd0, 3'd2, 2'b00, 32'h44);
        wait_grant(0);
        req_valid[0] = 1'b0;
        tick();
        rd_done       = 1'b1;
        rd_data_valid = 1'b1;
        rd_data       = 32'h55;
        tick();
        rd_done       = 1'b0;
        rd_data_valid = 1'b0;
        rd_data       = '0;
        check("t4_busy", busy, 1'b1);
        check("t4_wr_addr_hold", wr_addr, 32'h4000);
        check("t4_wr_data_hold", wr_data, 32'h44);
        check("t4_rd_addr_kept", rd_addr, 32'h2000);
        check("t4_rd_len_kept", rd_len, 8'd7);
        tick();
        check("t4_busy_later", busy, 1'b1);
        wr_done = 1'b1;
        push_done(0, 1'b0, cyc + 1);
        tick();
        wr_done = 1'b0;
        wait_idle();

        // Timeout with no done, then the waiting requester is served
        issue(0, 1'b1, 32'h5000, 8'd2, 3'd2, 2'b01, 32'h500);
        g = cyc + 1;
        push_done(0, 1'b1, g + TMO);
        wait_grant(0);
        req_valid[0] = 1'b0;
        repeat (5) tick();
        set_req(1, 1'b0, 32'h6000, 8'd1, 3'd2, 2'b01, 32'h0);
        push_grant(1, 1'b0, 32'h6000, 8'd1, 3'd2, 2'b01, 32'h0, g + TMO + 2);
        wait_grant(1);
        req_valid[1] = 1'b0;
        tick();
        rd_done = 1'b1;
        push_done(1, 1'b0, cyc + 1);
        tick();
        rd_done = 1'b0;
        wait_idle();

        // Done on the expiry edge completes without error
        issue(0, 1'b1, 32'h7000, 8'd0, 3'd2, 2'b01, 32'h700);
        wait_grant(0);
        req_valid[0] = 1'b0;
        repeat (TMO - 1) tick();
        wr_done = 1'b1;
        push_done(0, 1'b0, cyc + 1);
        tick();
        wr_done = 1'b0;
        wait_idle();

        // Reset in the middle of a read, then req0 must win a simultaneous request
        issue(1, 1'b0, 32'h8000, 8'd3, 3'd2, 2'b01, 32'h0);
        wait_grant(1);
        req_valid[1]  = 1'b0;
        rd_data_valid = 1'b1;
        rd_data       = 32'h800;
        push_rd(1, 32'h800, cyc);
        tick();
        rd_data_valid = 1'b0;
        rd_data       = '0;
        reset = 1'b1;
        tick();
        check_reset_outputs("t6");
        reset = 1'b0;
        set_req(0, 1'b1, 32'h9000, 8'd1, 3'd2, 2'b01, 32'h900);
        set_req(1, 1'b0, 32'h9100, 8'd2, 3'd2, 2'b01, 32'h0);
        push_grant(0, 1'b1, 32'h9000, 8'd1, 3'd2, 2'b01, 32'h900, cyc + 1);
        wait_grant(0);
        req_valid[0] = 1'b0;
        tick();
        wr_done = 1'b1;
        push_done(0, 1'b0, cyc + 1);
        push_grant(1, 1'b0, 32'h9100, 8'd2, 3'd2, 2'b01, 32'h0, cyc + 3);
        tick();
        wr_done = 1'b0;
        wait_grant(1);
        req_valid[1] = 1'b0;
        tick();
        rd_done = 1'b1;
        push_done(1, 1'b0, cyc + 1);
        tick();
        rd_done = 1'b0;
        wait_idle();

        repeat (4) tick();
        check("grant_queue_drained", grant_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
        check("rd_queue_drained", rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
